// File: rtl/riscv_fetch_unit.sv
// Fetch stage for a RISC-V core: in-order word requests to instruction memory,
// a prefetch FIFO toward the core, and redirect handling that drops stale responses.
`timescale 1ns/1ps
module riscv_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;
  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam logic [CW:0] FULL_CREDIT = (CW+1)'(DEPTH);

  state_t          r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc;
  cnt_t            r_count, r_outstanding, r_drop_cnt;
  ptr_t            r_wr_ptr, r_rd_ptr, r_rq_wr_ptr, r_rq_rd_ptr;
  logic [XLEN-1:0] r_fifo_inst [DEPTH];
  logic [XLEN-1:0] r_fifo_pc   [DEPTH];
  logic [XLEN-1:0] r_rq_pc     [DEPTH];

  logic            w_req_fire, w_rsp_fire, w_rsp_drop, w_push, w_pop;
  logic [CW:0]     w_credit_used;
  cnt_t            w_drop_on_redirect;
  logic [1:0]      w_unused_pc_lsb;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_unused_pc_lsb = redirect_pc[1:0];

  // Credits cover both buffered words and words still in flight, so a
  // response always finds a free FIFO slot.
  assign w_credit_used  = {1'b0, r_count} + {1'b0, r_outstanding};
  assign imem_req_valid = (r_state == S_RUN) && (w_credit_used < FULL_CREDIT) && !redirect;
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign w_rsp_fire         = imem_rsp_valid && (r_outstanding != '0);
  assign w_rsp_drop         = (r_state == S_FLUSH) || redirect;
  assign w_push             = w_rsp_fire && !w_rsp_drop;
  assign w_drop_on_redirect = r_outstanding - cnt_t'(w_rsp_fire);

  assign inst_valid = (r_count != '0);
  assign w_pop      = inst_valid && inst_ready;
  assign inst       = inst_valid ? r_fifo_inst[r_rd_ptr] : '0;
  assign inst_pc    = inst_valid ? r_fifo_pc[r_rd_ptr]   : '0;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  w_state_nxt = S_RUN;
      S_RUN:   if (redirect && (w_drop_on_redirect != '0)) w_state_nxt = S_FLUSH;
      S_FLUSH: begin
        if (redirect)
          w_state_nxt = (w_drop_on_redirect != '0) ? S_FLUSH : S_RUN;
        else if (w_rsp_fire && (r_drop_cnt == cnt_t'(1)))
          w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_rq_wr_ptr   <= '0;
      r_rq_rd_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (redirect)        r_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (w_req_fire) r_pc <= r_pc + XLEN'(4);

      r_outstanding <= r_outstanding + cnt_t'(w_req_fire) - cnt_t'(w_rsp_fire);
      if (redirect)
        r_drop_cnt <= w_drop_on_redirect;
      else if (w_rsp_fire && (r_state == S_FLUSH))
        r_drop_cnt <= r_drop_cnt - 1'b1;

      // The request-PC queue survives a redirect: stale responses still retire its entries.
      if (w_req_fire) r_rq_wr_ptr <= ptr_inc(r_rq_wr_ptr);
      if (w_rsp_fire) r_rq_rd_ptr <= ptr_inc(r_rq_rd_ptr);

      if (redirect) begin
        r_count  <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
        if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
        r_count <= r_count + cnt_t'(w_push) - cnt_t'(w_pop);
      end
    end
  end

  // NOTE: storage arrays are not reset; validity lives in the counters and the
  // outputs are masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_req_fire) r_rq_pc[r_rq_wr_ptr] <= r_pc;
    if (w_push) begin
      r_fifo_inst[r_wr_ptr] <= imem_rsp_data;
      r_fifo_pc[r_wr_ptr]   <= r_rq_pc[r_rq_rd_ptr];
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    w_push |-> (r_count < cnt_t'(DEPTH)));
  a_drop_bound: assert property (@(posedge clk) disable iff (!rst)
    r_drop_cnt <= r_outstanding);

endmodule
